// File: rtl/up_irq_ctrl_if.sv
// Port-bus connection for up_irq_ctrl: block select, register address,
// read/write strobes and the 8-bit data paths.
// The CPU side uses master and the interrupt controller uses slave.
interface up_irq_ctrl_if;
   logic       pi_blk_sel;
   logic [3:0] pi_addr;
   logic       pi_wr_en;
   logic       pi_rd_en;
   logic [7:0] pi_wr_data;
   logic [7:0] pi_rd_data;

   modport master (
      output pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
      input  pi_rd_data
   );

   modport slave (
      input  pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
      output pi_rd_data
   );
endinterface

// File: rtl/up_irq_ctrl.sv
// up_irq_ctrl: interrupt controller for the 8-bit soft CPU.
// It latches rising edges on the peripheral interrupt lines, masks them and picks a single winner.
// It raises interrupt until the CPU sends interrupt_ack, then holds the in-service source until EOI.
// Optional feature: define INTC_ROUND_ROBIN_EN for rotating priority.
// The rotation starts after the last source that received EOI.
// Without it, priority is fixed and the lowest index wins.
module up_irq_ctrl #(
   parameter int unsigned NUM_SRC = 3
) (
   input  logic               clk,
   input  logic               rst,
   up_irq_ctrl_if.slave       bus,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic               interrupt,
   input  logic               interrupt_ack
);

   typedef logic [NUM_SRC-1:0] src_t;
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t     state_q, state_d;
   src_t       pending_q, pending_d;
   src_t       mask_q;
   src_t       irq_src_q;
   logic       ctrl_q;
   logic [2:0] id_q;
   logic [7:0] rd_data_q, rd_mux;
   logic       interrupt_q, interrupt_d;

   logic       wr_stb, eoi;
   src_t       req_vec, rise, clr, search;
   logic [2:0] base, winner;
   logic [3:0] sum;
   logic       found;
   logic       unused_ok;

`ifdef INTC_ROUND_ROBIN_EN
   logic [2:0] ptr_q;
   assign base = ptr_q;
`else
   assign base = 3'd0;
`endif

   assign wr_stb    = bus.pi_blk_sel & bus.pi_wr_en;
   assign eoi       = wr_stb && (bus.pi_addr == 4'h4) && (state_q == SERVICE);
   assign req_vec   = pending_q & mask_q;
   assign interrupt = interrupt_q;
   assign bus.pi_rd_data = rd_data_q;
   // Reads do not need the strobe, and only the low NUM_SRC data bits reach the registers.
   assign unused_ok = &{1'b0, bus.pi_rd_en, bus.pi_wr_data};

   // Winner search: rotate the request vector so the search starts at base, then take the first set bit.
   always_comb begin
      search = src_t'({req_vec, req_vec} >> base);
      winner = '0;
      sum    = '0;
      found  = 1'b0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (!found && search[k]) begin
            found  = 1'b1;
            sum    = 4'(base) + 4'(k);
            winner = (sum >= 4'(NUM_SRC)) ? 3'(sum - 4'(NUM_SRC)) : 3'(sum);
         end
      end
   end

   // Pending update: a new edge wins over a CLEAR or EOI clear of the same bit.
   always_comb begin
      rise = irq_src & ~irq_src_q;
      clr  = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         clr[k] = eoi && (id_q == 3'(k));
      end
      if (wr_stb && (bus.pi_addr == 4'h3)) begin
         clr = clr | bus.pi_wr_data[NUM_SRC-1:0];
      end
      pending_d = (pending_q & ~clr) | rise;
   end

   // Register read mux, zero-extended to the 8-bit bus; returns 0 when the block is not selected.
   always_comb begin
      rd_mux = '0;
      if (bus.pi_blk_sel) begin
         case (bus.pi_addr)
            4'h0: rd_mux[NUM_SRC-1:0] = pending_q;
            4'h1: rd_mux[NUM_SRC-1:0] = mask_q;
            4'h2: if (state_q != IDLE) rd_mux = {1'b1, 4'b0000, id_q};
            4'h5: rd_mux[0] = ctrl_q;
            default: ;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: request, wait for ack, then wait for EOI.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ctrl_q && (|req_vec)) state_d = REQ;
         REQ:     if (interrupt_ack)        state_d = SERVICE;
         SERVICE: if (eoi)                  state_d = IDLE;
         default:                           state_d = IDLE;
      endcase
   end

   // FSM output: interrupt is registered and is high for as long as the FSM is in REQ.
   always_comb begin
      interrupt_d = (state_d == REQ);
   end

   // Datapath registers: edge history, pending, control registers, winner id and read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_src_q   <= '0;
         pending_q   <= '0;
         mask_q      <= '0;
         ctrl_q      <= 1'b0;
         id_q        <= '0;
         rd_data_q   <= '0;
         interrupt_q <= 1'b0;
`ifdef INTC_ROUND_ROBIN_EN
         ptr_q       <= '0;
`endif
      end else begin
         irq_src_q   <= irq_src;
         pending_q   <= pending_d;
         rd_data_q   <= rd_mux;
         interrupt_q <= interrupt_d;
         if (wr_stb && (bus.pi_addr == 4'h1)) mask_q <= bus.pi_wr_data[NUM_SRC-1:0];
         if (wr_stb && (bus.pi_addr == 4'h5)) ctrl_q <= bus.pi_wr_data[0];
         if ((state_q == IDLE) && (state_d == REQ)) id_q <= winner;
         else if (eoi)                              id_q <= '0;
`ifdef INTC_ROUND_ROBIN_EN
         if (eoi) ptr_q <= (4'(id_q) + 4'd1 >= 4'(NUM_SRC)) ? 3'd0 : id_q + 3'd1;
`endif
      end
   end

endmodule

// File: tb/tb_up_irq_ctrl.sv
// Testbench for up_irq_ctrl.
// Directed register-level scenarios are followed by a randomized phase.
// A cycle-level reference model, built from the controller's rules, predicts the interrupt line and the registered read data.
module tb_up_irq_ctrl;
   localparam int N = 3;
   localparam bit [7:0] LOW = 8'((1 << N) - 1);

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] irq_src;
   logic         interrupt;
   logic         interrupt_ack;

   up_irq_ctrl_if bus();

   up_irq_ctrl #(.NUM_SRC(N)) dut (
      .clk(clk), .rst(rst), .bus(bus), .irq_src(irq_src),
      .interrupt(interrupt), .interrupt_ack(interrupt_ack)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nfail = 0;

   // Reference model: phase 0 = nothing in progress, 1 = requesting the CPU, 2 = serving until EOI.
   bit [7:0] m_pend, m_mask, m_srcd, m_rd;
   bit       m_en, m_int;
   int       m_phase, m_id, m_ptr;

   function automatic bit [7:0] m_reg(input bit [3:0] a);
      case (a)
         4'h0: return m_pend;
         4'h1: return m_mask;
         4'h2: return (m_phase != 0) ? (8'h80 | 8'(m_id)) : 8'h00;
         4'h5: return {7'b0, m_en};
         default: return 8'h00;
      endcase
   endfunction

   function automatic int m_pick();
      bit [7:0] v;
      v = m_pend & m_mask;
      for (int k = 0; k < N; k++) begin
         int s;
         s = (m_ptr + k) % N;
         if (v[s[2:0]]) return s;
      end
      return 0;
   endfunction

   task automatic model_edge();
      bit [7:0] rise, clr;
      bit wr, eoi;
      int nxt;
      if (rst) begin
         m_pend = 0; m_mask = 0; m_srcd = 0; m_rd = 0; m_en = 0;
         m_int = 0; m_phase = 0; m_id = 0; m_ptr = 0;
         return;
      end
      m_rd = bus.pi_blk_sel ? m_reg(bus.pi_addr) : 8'h00;
      rise = 8'(irq_src) & ~m_srcd;
      m_srcd = 8'(irq_src);
      wr  = bus.pi_blk_sel && bus.pi_wr_en;
      eoi = wr && (bus.pi_addr == 4'h4) && (m_phase == 2);
      clr = 0;
      if (wr && bus.pi_addr == 4'h3) clr = bus.pi_wr_data & LOW;
      if (eoi) clr = clr | 8'(1 << m_id);
      nxt = m_phase;
      if (m_phase == 0 && m_en && ((m_pend & m_mask) != 0)) begin
         m_id = m_pick();
         nxt = 1;
      end else if (m_phase == 1 && interrupt_ack) begin
         nxt = 2;
      end else if (eoi) begin
         nxt = 0;
`ifdef INTC_ROUND_ROBIN_EN
         m_ptr = (m_id + 1) % N;
`endif
      end
      m_phase = nxt;
      m_pend = (m_pend & ~clr) | rise;
      if (wr && bus.pi_addr == 4'h1) m_mask = bus.pi_wr_data & LOW;
      if (wr && bus.pi_addr == 4'h5) m_en = bus.pi_wr_data[0];
      m_int = (m_phase == 1);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("interrupt", {7'b0, interrupt}, {7'b0, m_int});
      chk("rd_data", bus.pi_rd_data, m_rd);
   endtask

   task automatic bus_idle();
      bus.pi_blk_sel = 0; bus.pi_addr = 0; bus.pi_wr_en = 0;
      bus.pi_rd_en = 0; bus.pi_wr_data = 0;
   endtask

   task automatic wr(input bit [3:0] a, input bit [7:0] d);
      bus.pi_blk_sel = 1; bus.pi_wr_en = 1; bus.pi_addr = a; bus.pi_wr_data = d;
      cyc();
      bus_idle();
   endtask

   task automatic rd(input bit [3:0] a, input bit [7:0] exp, input string tag);
      bus.pi_blk_sel = 1; bus.pi_rd_en = 1; bus.pi_addr = a;
      cyc();
      chk(tag, bus.pi_rd_data, exp);
      bus_idle();
   endtask

   task automatic pulse(input bit [N-1:0] s);
      irq_src = s;
      cyc();
      irq_src = '0;
   endtask

   task automatic ack();
      interrupt_ack = 1;
      cyc();
      interrupt_ack = 0;
   endtask

   initial begin
      rst = 1; irq_src = '0; interrupt_ack = 0;
      bus_idle();
      cyc(); cyc();
      rst = 0;

      // 1: reset values, and a read while the block is not selected
      for (int a = 0; a < 6; a++) rd(4'(a), 8'h00, "reset_reg");
      chk("reset_int", {7'b0, interrupt}, 8'h00);
      bus.pi_blk_sel = 0; bus.pi_rd_en = 1; bus.pi_addr = 4'h1;
      cyc();
      chk("unselected_rd", bus.pi_rd_data, 8'h00);
      bus_idle();

      // 2: single source served end to end
      wr(4'h1, 8'h07);
      wr(4'h5, 8'h01);
      pulse(3'b010);
      cyc();
      rd(4'h0, 8'h02, "t2_status");
      rd(4'h2, 8'h81, "t2_id");
      chk("t2_int", {7'b0, interrupt}, 8'h01);
      ack();
      chk("t2_int_ack", {7'b0, interrupt}, 8'h00);
      wr(4'h4, 8'h00);
      rd(4'h0, 8'h00, "t2_status_eoi");
      rd(4'h2, 8'h00, "t2_id_eoi");

      // 3: a masked source still latches, and the request fires once it is unmasked
      wr(4'h1, 8'h00);
      pulse(3'b100);
      cyc(); cyc();
      chk("t3_masked_int", {7'b0, interrupt}, 8'h00);
      rd(4'h0, 8'h04, "t3_status");
      wr(4'h1, 8'h04);
      cyc();
      chk("t3_int", {7'b0, interrupt}, 8'h01);
      rd(4'h2, 8'h82, "t3_id");
      ack();
      wr(4'h4, 8'h00);

      // 4: simultaneous edges on src0 and src2; the pointer is 0 here, so both modes pick src0 first
      wr(4'h1, 8'h07);
      pulse(3'b101);
      cyc();
      rd(4'h2, 8'h80, "t4_id_first");
      ack();
      wr(4'h4, 8'h00);
      cyc();
      rd(4'h2, 8'h82, "t4_id_second");
      ack();
      wr(4'h4, 8'h00);
`ifdef INTC_ROUND_ROBIN_EN
      pulse(3'b001);
      cyc();
      rd(4'h2, 8'h80, "t4rr_src0");
      ack();
      wr(4'h4, 8'h00);
      pulse(3'b101);
      cyc();
      rd(4'h2, 8'h82, "t4rr_first");
      ack();
      wr(4'h4, 8'h00);
      cyc();
      rd(4'h2, 8'h80, "t4rr_second");
      ack();
      wr(4'h4, 8'h00);
`endif

      // 5: a CLEAR in the same cycle as a rising edge leaves the bit set
      irq_src = 3'b010;
      bus.pi_blk_sel = 1; bus.pi_wr_en = 1; bus.pi_addr = 4'h3; bus.pi_wr_data = 8'h02;
      cyc();
      bus_idle(); irq_src = '0;
      rd(4'h0, 8'h02, "t5_status");
      cyc();
      chk("t5_int", {7'b0, interrupt}, 8'h01);

      // 6: reset while requesting
      rst = 1;
      cyc();
      rst = 0;
      chk("t6_int", {7'b0, interrupt}, 8'h00);
      rd(4'h0, 8'h00, "t6_status");
      rd(4'h1, 8'h00, "t6_mask");
      rd(4'h2, 8'h00, "t6_id");
      rd(4'h5, 8'h00, "t6_ctrl");

      // Randomized traffic checked cycle by cycle against the model
      wr(4'h1, 8'h07);
      wr(4'h5, 8'h01);
      for (int c = 0; c < 3000; c++) begin
         int op;
         irq_src       = N'($urandom);
         interrupt_ack = ($urandom_range(0, 3) == 0);
         rst           = ($urandom_range(0, 499) == 0);
         op            = $urandom_range(0, 9);
         bus.pi_blk_sel = ($urandom_range(0, 7) != 0);
         bus.pi_addr    = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
         bus.pi_wr_en   = (op < 3);
         bus.pi_rd_en   = (op >= 3 && op < 6);
         bus.pi_wr_data = 8'($urandom);
         if (bus.pi_addr == 4'h5) bus.pi_wr_data[0] = ($urandom_range(0, 4) != 0);
         cyc();
      end
      rst = 0; irq_src = '0; interrupt_ack = 0;
      bus_idle();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
